// File: rtl/ks_pluck_ctrl.sv
// Karplus-Strong voice sequencer: pitch divider, LFSR noise-burst excitation
// and the IDLE/EXCITE/RING/DAMP lifecycle driving one string's ena/filter_ena/d.
module ks_pluck_ctrl #(
  parameter int unsigned datawidth = 16,
  parameter int unsigned depthbits = 12,
  parameter int unsigned divbits   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 pluck,
  input  logic                 damp,
  input  logic [divbits-1:0]   period,
  input  logic [3:0]           amp_shift,
  output logic                 ks_ena,
  output logic                 ks_filter_ena,
  output logic [datawidth-1:0] ks_d,
  output logic                 busy,
  output logic [1:0]           state
);

  localparam logic [31:0] LFSR_SEED = 32'hACE1ACE1;
  localparam logic [31:0] LFSR_TAPS = 32'h80200003;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EXCITE = 2'd1,
    RING   = 2'd2,
    DAMP   = 2'd3
  } state_t;

  state_t cur_q, nxt;

  logic [divbits-1:0]   per_q, per_d;
  logic [divbits-1:0]   div_q, div_d;
  logic [3:0]           amp_q, amp_d;
  logic [31:0]          lfsr_q, lfsr_d;
  logic [depthbits-1:0] cnt_q, cnt_d;
  logic                 ks_ena_d, filt_d, busy_q;
  logic [datawidth-1:0] ks_d_d;
  logic signed [datawidth-1:0] noise;
  logic                 strobe, terminal;

  assign strobe   = (cur_q != IDLE) && (div_q == '0);
  assign terminal = (cnt_q == '1);
  assign state    = cur_q;
  assign busy     = busy_q;

  always_ff @(posedge clk) begin
    if (reset) cur_q <= IDLE;
    else       cur_q <= nxt;
  end

  always_comb begin
    nxt = cur_q;
    if (pluck) begin
      nxt = EXCITE;
    end else begin
      unique case (cur_q)
        EXCITE:  if (strobe && terminal) nxt = RING;
        RING:    if (damp) nxt = DAMP;
        DAMP:    if (strobe && terminal) nxt = IDLE;
        default: nxt = cur_q;
      endcase
    end
  end

  // Next values of every registered output are computed from the next state,
  // so each output flop matches the state it will be presented with.
  always_comb begin
    per_d  = per_q;
    amp_d  = amp_q;
    div_d  = div_q;
    cnt_d  = cnt_q;
    lfsr_d = lfsr_q;
    if ((cur_q == EXCITE) && strobe)
      lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    if (pluck) begin
      per_d = (period < divbits'(2)) ? divbits'(2) : period;
      amp_d = amp_shift;
      div_d = per_d - divbits'(1);
      cnt_d = '0;
    end else if (cur_q != IDLE) begin
      div_d = strobe ? (per_q - divbits'(1)) : (div_q - divbits'(1));
      if ((cur_q == RING) && damp)
        cnt_d = '0;
      else if (strobe && ((cur_q == EXCITE) || (cur_q == DAMP)))
        cnt_d = cnt_q + depthbits'(1);
    end
    ks_ena_d = (nxt != IDLE) && (div_d == '0);
    filt_d   = (nxt == DAMP) || ((nxt == RING) && ks_ena_d);
    noise    = lfsr_d[31 -: datawidth];
    noise    = noise >>> amp_d;
    ks_d_d   = (nxt == EXCITE) ? noise : '0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      per_q         <= divbits'(2);
      amp_q         <= '0;
      div_q         <= '0;
      cnt_q         <= '0;
      lfsr_q        <= LFSR_SEED;
      ks_ena        <= 1'b0;
      ks_filter_ena <= 1'b0;
      ks_d          <= '0;
      busy_q        <= 1'b0;
    end else begin
      per_q         <= per_d;
      amp_q         <= amp_d;
      div_q         <= div_d;
      cnt_q         <= cnt_d;
      lfsr_q        <= lfsr_d;
      ks_ena        <= ks_ena_d;
      ks_filter_ena <= filt_d;
      ks_d          <= ks_d_d;
      busy_q        <= (nxt != IDLE);
    end
  end

endmodule

// File: tb/tb_ks_pluck_ctrl.sv
// Directed bench for ks_pluck_ctrl (depthbits=3): hand-computed checkpoints
// plus a small cycle model of the voice lifecycle.
module tb_ks_pluck_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pluck = 1'b0;
  logic        damp = 1'b0;
  logic [15:0] period = 16'd5;
  logic [3:0]  amp_shift = 4'd0;
  logic        ks_ena, ks_filter_ena, busy;
  logic [15:0] ks_d;
  logic [1:0]  state;

  int tests = 0;
  int fails = 0;

  int          m_state, m_p, m_k, m_cnt, m_amp;
  logic [31:0] m_lfsr;

  logic [15:0] hand [4] = '{16'hACE1, 16'hD650, 16'hEB08, 16'h7584};

  always #5 clk = ~clk;

  ks_pluck_ctrl #(.datawidth(16), .depthbits(3), .divbits(16)) dut (
    .clk(clk), .reset(reset), .pluck(pluck), .damp(damp),
    .period(period), .amp_shift(amp_shift),
    .ks_ena(ks_ena), .ks_filter_ena(ks_filter_ena), .ks_d(ks_d),
    .busy(busy), .state(state)
  );

  function automatic logic [31:0] adv(input logic [31:0] x);
    logic [31:0] y;
    y = x >> 1;
    if (x[0]) y = y ^ 32'h80200003;
    return y;
  endfunction

  function automatic logic [15:0] noise16(input logic [31:0] x, input int a);
    logic signed [15:0] s;
    s = x[31:16];
    return s >>> a;
  endfunction

  task automatic model_reset();
    m_state = 0; m_p = 2; m_k = 1; m_cnt = 0; m_amp = 0;
    m_lfsr  = 32'hACE1ACE1;
  endtask

  // Check this cycle's outputs against the model, then advance one clock.
  task automatic step(input string tag);
    logic       exp_ena, exp_filt;
    logic [15:0] exp_d;
    exp_ena  = (m_state != 0) && ((m_k % m_p) == 0);
    exp_filt = (m_state == 3) || ((m_state == 2) && exp_ena);
    exp_d    = (m_state == 1) ? noise16(m_lfsr, m_amp) : 16'h0;
    tests += 5;
    if (ks_ena !== exp_ena) begin
      fails++; $display("FAIL %s ks_ena k=%0d: got %b expected %b", tag, m_k, ks_ena, exp_ena);
    end
    if (ks_filter_ena !== exp_filt) begin
      fails++; $display("FAIL %s ks_filter_ena k=%0d: got %b expected %b", tag, m_k, ks_filter_ena, exp_filt);
    end
    if (ks_d !== exp_d) begin
      fails++; $display("FAIL %s ks_d k=%0d: got %h expected %h", tag, m_k, ks_d, exp_d);
    end
    if (state !== 2'(m_state)) begin
      fails++; $display("FAIL %s state k=%0d: got %0d expected %0d", tag, m_k, state, m_state);
    end
    if (busy !== (m_state != 0)) begin
      fails++; $display("FAIL %s busy k=%0d: got %b expected %b", tag, m_k, busy, m_state != 0);
    end
    if (reset) begin
      model_reset();
    end else if (pluck) begin
      if ((m_state == 1) && exp_ena) m_lfsr = adv(m_lfsr);
      m_state = 1; m_p = (period < 2) ? 2 : int'(period);
      m_amp = int'(amp_shift); m_k = 0; m_cnt = 0;
    end else if ((m_state == 1) && exp_ena) begin
      m_lfsr = adv(m_lfsr);
      m_cnt++;
      if (m_cnt == 8) begin m_state = 2; m_cnt = 0; end
    end else if ((m_state == 3) && exp_ena) begin
      m_cnt++;
      if (m_cnt == 8) begin m_state = 0; m_cnt = 0; end
    end else if ((m_state == 2) && damp) begin
      m_state = 3; m_cnt = 0;
    end
    m_k++;
    @(posedge clk); #1;
  endtask

  task automatic do_pluck(input logic [15:0] per, input logic [3:0] amp, input logic with_damp);
    period = per; amp_shift = amp; pluck = 1'b1; damp = with_damp;
    step("pluck");
    pluck = 1'b0; damp = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    model_reset();
    step("reset");
    step("reset");
    reset = 1'b0;
    for (int i = 0; i < 100; i++) step("idle");
  endtask

  task automatic test_excite();
    int seen;
    seen = 0;
    do_pluck(16'd5, 4'd0, 1'b0);
    for (int k = 1; k <= 40; k++) begin
      if ((k % 5) == 1) begin
        tests++;
        if ((k <= 16) && (ks_d !== hand[(k - 1) / 5])) begin
          fails++; $display("FAIL excite_hand k=%0d: got %h expected %h", k, ks_d, hand[(k - 1) / 5]);
        end
      end
      if (ks_ena === 1'b1) seen++;
      step("excite");
    end
    tests += 2;
    if (seen != 8) begin
      fails++; $display("FAIL excite_strobes: got %0d expected 8", seen);
    end
    if (state !== 2'd2) begin
      fails++; $display("FAIL excite_to_ring: got %0d expected 2", state);
    end
    for (int i = 0; i < 20; i++) step("ring");
  endtask

  task automatic test_min_period();
    logic [15:0] prev;
    for (int p = 0; p < 2; p++) begin
      do_pluck(16'(p), 4'd3, 1'b0);
      prev = ks_d;
      for (int k = 1; k <= 16; k++) begin
        if (ks_ena === 1'b1) begin
          tests++;
          if (ks_d !== prev) begin
            fails++; $display("FAIL minper_stable p=%0d k=%0d: got %h expected %h", p, k, ks_d, prev);
          end
        end
        prev = ks_d;
        step("minper");
      end
      tests++;
      if (state !== 2'd2) begin
        fails++; $display("FAIL minper_ring p=%0d: got %0d expected 2", p, state);
      end
    end
  endtask

  task automatic test_damp();
    step("ring");
    damp = 1'b1;
    step("damp_req");
    damp = 1'b0;
    tests += 2;
    if (state !== 2'd3) begin
      fails++; $display("FAIL damp_state: got %0d expected 3", state);
    end
    if (ks_filter_ena !== 1'b1) begin
      fails++; $display("FAIL damp_filter: got %b expected 1", ks_filter_ena);
    end
    damp = 1'b1;
    step("damp_again");
    damp = 1'b0;
    for (int i = 0; i < 15; i++) step("damp");
    tests += 2;
    if (state !== 2'd0) begin
      fails++; $display("FAIL damp_idle_state: got %0d expected 0", state);
    end
    if (busy !== 1'b0) begin
      fails++; $display("FAIL damp_idle_busy: got %b expected 0", busy);
    end
    for (int i = 0; i < 10; i++) step("post_damp");
  endtask

  task automatic test_back_to_back();
    do_pluck(16'd2, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) step("b2b_excite");
    do_pluck(16'd3, 4'd1, 1'b1);
    tests++;
    if (state !== 2'd1) begin
      fails++; $display("FAIL b2b_retrigger: got %0d expected 1", state);
    end
    step("b2b");
    damp = 1'b1;
    step("b2b_damp_ignored");
    damp = 1'b0;
    for (int i = 0; i < 7; i++) step("b2b");
    do_pluck(16'd4, 4'd2, 1'b0);
    for (int i = 0; i < 31; i++) step("b2b_burst");
    tests++;
    if (state !== 2'd1) begin
      fails++; $display("FAIL b2b_still_excite: got %0d expected 1", state);
    end
    step("b2b_last");
    tests++;
    if (state !== 2'd2) begin
      fails++; $display("FAIL b2b_ring: got %0d expected 2", state);
    end
  endtask

  task automatic test_reset_mid();
    do_pluck(16'd5, 4'd0, 1'b0);
    for (int i = 0; i < 7; i++) step("mid");
    reset = 1'b1;
    step("mid_reset");
    reset = 1'b0;
    tests++;
    if ({ks_ena, ks_filter_ena, ks_d, busy, state} !== 20'h0) begin
      fails++; $display("FAIL reset_mid: got %h expected 0", {ks_ena, ks_filter_ena, ks_d, busy, state});
    end
    for (int i = 0; i < 3; i++) step("mid_idle");
    do_pluck(16'd5, 4'd0, 1'b0);
    tests++;
    if (ks_d !== 16'hACE1) begin
      fails++; $display("FAIL replay_first: got %h expected ace1", ks_d);
    end
    for (int i = 0; i < 5; i++) step("replay");
    tests++;
    if (ks_d !== 16'hD650) begin
      fails++; $display("FAIL replay_second: got %h expected d650", ks_d);
    end
    for (int i = 0; i < 10; i++) step("replay");
  endtask

  initial begin
    test_reset();
    test_excite();
    test_min_period();
    test_damp();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
